// File: rtl/seq_mul_if.sv
// Handshake/operand bundle for seq_mul: the master drives start and operands, the slave returns busy/done/y.
interface seq_mul_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;

  modport master (
    output start, a, b, sgn,
    input  busy, done, y
  );

  modport slave (
    input  start, a, b, sgn,
    output busy, done, y
  );
endinterface

// File: rtl/seq_mul.sv
// Shift-add sequential multiplier that does one partial-product add per clock and W clocks per product.
// Optional two's-complement mode is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_mul #(
  parameter int W = 4
) (
  input logic      clk,
  input logic      rst,
  seq_mul_if.slave bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  logic [2*W-1:0] r_ra;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_y;
  logic [W-1:0]   r_rb;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;
  logic           r_busy;
  logic           r_done;

  logic           w_sgn;
  logic [W-1:0]   w_absA;
  logic [W-1:0]   w_absB;
  logic [2*W-1:0] w_accNext;

  // The magnitude of -2^(W-1) is 2^(W-1), which is still exact as a W-bit unsigned value.
  always_comb begin
`ifdef SEQ_MUL_SIGNED_EN
    w_sgn  = bus.sgn;
    w_absA = (bus.sgn && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
    w_absB = (bus.sgn && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;
`else
    w_sgn  = 1'b0;
    w_absA = bus.a;
    w_absB = bus.b;
`endif
    w_accNext = r_acc + (r_rb[0] ? r_ra : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_rb    <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_ra    <= {{W{1'b0}}, w_absA};
            r_rb    <= w_absB;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= w_sgn & (bus.a[W-1] ^ bus.b[W-1]);
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_acc <= w_accNext;
          r_ra  <= r_ra << 1;
          r_rb  <= r_rb >> 1;
          r_cnt <= r_cnt + 1'b1;
          // The last step must include this cycle's add, so the result comes from w_accNext.
          if (r_cnt == CW'(W - 1)) begin
            r_y     <= r_neg ? (~w_accNext + 1'b1) : w_accNext;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.y    = r_y;

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul, with W=4 and W=8 instances checked against an arithmetic reference model.
// The signed expectations follow SEQ_MUL_SIGNED_EN in the same way as the design.
module tb_seq_mul;

`ifdef SEQ_MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] yExp4;
  logic [63:0] yExp8;

  seq_mul_if #(.W(4)) bus4 ();
  seq_mul_if #(.W(8)) bus8 ();

  seq_mul #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_mul #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: sign-extend the operands only when the signed mode applies, then truncate to 2W bits.
  function automatic logic [63:0] refMul(logic [31:0] a, logic [31:0] b, bit sgn, int w);
    longint      sa;
    longint      sb;
    longint      p;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (SIGNED_EN && sgn) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    p = sa * sb;
    return 64'(p) & mask;
  endfunction

  function automatic logic obsBusy(int which);
    return (which == 0) ? bus4.busy : bus8.busy;
  endfunction

  function automatic logic obsDone(int which);
    return (which == 0) ? bus4.done : bus8.done;
  endfunction

  function automatic logic [63:0] obsY(int which);
    return (which == 0) ? {56'd0, bus4.y} : {48'd0, bus8.y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int which, bit start, logic [31:0] a, logic [31:0] b, bit sgn);
    if (which == 0) begin
      bus4.start = start;
      bus4.a     = a[3:0];
      bus4.b     = b[3:0];
      bus4.sgn   = sgn;
    end else begin
      bus8.start = start;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.sgn   = sgn;
    end
  endtask

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Accept one product, then check busy for W cycles, the done pulse with the new y, and the idle cycle afterwards.
  task automatic runOp(int which, logic [31:0] a, logic [31:0] b, bit sgn, string tag);
    int          w;
    logic [63:0] exp;
    logic [63:0] held;
    w    = (which == 0) ? 4 : 8;
    a    = a & ((32'd1 << w) - 32'd1);
    b    = b & ((32'd1 << w) - 32'd1);
    exp  = refMul(a, b, sgn, w);
    held = (which == 0) ? yExp4 : yExp8;
    applyStimulus(which, 1'b1, a, b, sgn);
    tick();
    applyStimulus(which, 1'b0, $urandom, $urandom, 1'($urandom));
    for (int k = 0; k < w; k++) begin
      checkOutput({tag, "_busy"}, 64'(obsBusy(which)), 64'd1);
      checkOutput({tag, "_noDone"}, 64'(obsDone(which)), 64'd0);
      checkOutput({tag, "_yHeld"}, obsY(which), held);
      tick();
    end
    checkOutput({tag, "_done"}, 64'(obsDone(which)), 64'd1);
    checkOutput({tag, "_busyLow"}, 64'(obsBusy(which)), 64'd0);
    checkOutput({tag, "_y"}, obsY(which), exp);
    tick();
    checkOutput({tag, "_donePulse"}, 64'(obsDone(which)), 64'd0);
    checkOutput({tag, "_idle"}, 64'(obsBusy(which)), 64'd0);
    checkOutput({tag, "_yKept"}, obsY(which), exp);
    if (which == 0) yExp4 = exp;
    else yExp8 = exp;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    yExp4    = '0;
    yExp8    = '0;
    rst      = 1'b1;
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_busy", 64'(bus4.busy), 64'd0);
    checkOutput("reset_done", 64'(bus4.done), 64'd0);
    checkOutput("reset_y", obsY(0), 64'd0);
    checkOutput("reset_y8", obsY(1), 64'd0);

    runOp(0, 15, 15, 1'b0, "max15x15");
    checkOutput("max15x15_const", obsY(0), 64'd225);
    runOp(0, 32'h8, 32'h8, 1'b1, "neg8xneg8");
    runOp(0, 32'hD, 32'h5, 1'b1, "neg3x5");
    runOp(0, 32'h7, 32'h8, 1'b1, "7xneg8");

    // A start during RUN must neither restart nor queue the product.
    applyStimulus(0, 1'b1, 2, 3, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 1, 1, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    checkOutput("midStart_busy", 64'(bus4.busy), 64'd1);
    tick();
    tick();
    checkOutput("midStart_done", 64'(bus4.done), 64'd1);
    checkOutput("midStart_y", obsY(0), refMul(2, 3, 1'b0, 4));
    tick();
    checkOutput("midStart_noQueue", 64'(bus4.busy), 64'd0);
    checkOutput("midStart_noDone", 64'(bus4.done), 64'd0);

    // With start held high, the second product is accepted in the DONE cycle.
    applyStimulus(0, 1'b1, 3, 4, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 5, 6, 1'b0);
    for (int k = 1; k < 4; k++) tick();
    checkOutput("b2b_busy3", 64'(bus4.busy), 64'd1);
    tick();
    checkOutput("b2b_done1", 64'(bus4.done), 64'd1);
    checkOutput("b2b_y1", obsY(0), refMul(3, 4, 1'b0, 4));
    tick();
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    checkOutput("b2b_restart", 64'(bus4.busy), 64'd1);
    checkOutput("b2b_doneLow", 64'(bus4.done), 64'd0);
    checkOutput("b2b_yHeld", obsY(0), refMul(3, 4, 1'b0, 4));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("b2b_noEarlyDone", 64'(bus4.done), 64'd0);
    end
    tick();
    checkOutput("b2b_done2", 64'(bus4.done), 64'd1);
    checkOutput("b2b_y2", obsY(0), refMul(5, 6, 1'b0, 4));
    tick();
    yExp4 = refMul(5, 6, 1'b0, 4);

    // Reset two cycles after start aborts the product and clears y.
    applyStimulus(0, 1'b1, 9, 7, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", 64'(bus4.busy), 64'd0);
    checkOutput("rst_done", 64'(bus4.done), 64'd0);
    checkOutput("rst_y", obsY(0), 64'd0);
    yExp4 = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("rst_noDone", 64'(bus4.done), 64'd0);
    end
    runOp(0, 11, 13, 1'b0, "afterRst");

    for (int n = 0; n < 12; n++) begin
      runOp(0, $urandom, $urandom, 1'($urandom), "rand4");
    end

    runOp(1, 32'hFF, 32'hFF, 1'b1, "w8_ffxff");
    runOp(1, 32'hFF, 32'hFF, 1'b0, "w8_ffxffU");
    runOp(1, 32'h80, 32'h80, 1'b1, "w8_minxmin");
    for (int n = 0; n < 6; n++) begin
      runOp(1, $urandom, $urandom, 1'($urandom), "rand8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
